// File: rtl/led_out_pkg.sv
// led_out_pkg
//   Shared definitions for the LED-panel output engine:
//   - FSM state encodings (legacy-compatible 3-bit constants)
//   - default parameter values
//   - helpers for counter sizing and frame-memory address packing
package led_out_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_PRIME  = 3'd1;
  localparam state_t ST_SHIFT  = 3'd2;
  localparam state_t ST_LATCH  = 3'd3;
  localparam state_t ST_SWITCH = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  localparam int DEF_CH        = 16;
  localparam int DEF_SCAN      = 16;
  localparam int DEF_COLS      = 64;
  localparam int DEF_DIV       = 2;
  localparam int DEF_RD_LAT    = 2;
  localparam int DEF_LE_W      = 2;
  localparam int DEF_BLANK_CYC = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // {bank, line, col}; callers truncate to their address width.
  function automatic logic [31:0] pack_adrs(input logic bank, input logic [31:0] line,
                                            input logic [31:0] col, input int scan_w,
                                            input int col_w);
    return (32'(bank) << (scan_w + col_w)) | (line << col_w) | col;
  endfunction

endpackage

// File: rtl/led_out_divider.sv
// led_out_divider
//   Column phase generator. Counts 2*DIV clk cycles per column while en is
//   high and produces the registered DCLK level plus two phase strobes.
// Ports:
//   clk, xrst  - clock, async active-low reset
//   en         - advance the phase; low clears phase and DCLK to 0
//   dclk       - registered shift clock, high for the second half of a column
//   col_end    - last cycle of the current column
//   capture    - cycle whose closing edge samples prefetched read data
module led_out_divider #(
  parameter int DIV    = 2,
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic xrst,
  input  logic en,
  output logic dclk,
  output logic col_end,
  output logic capture
);

  localparam int TOP  = 2 * DIV - 1;
  localparam int PH_W = $clog2(2 * DIV);

  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_nxt;

  always_comb begin
    ph_nxt = '0;
    if (en && (ph != PH_W'(TOP))) ph_nxt = ph + PH_W'(1);
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      ph   <= '0;
      dclk <= 1'b0;
    end else begin
      ph   <= ph_nxt;
      dclk <= en && (ph_nxt >= PH_W'(DIV));
    end
  end

  assign col_end = (ph == PH_W'(TOP));
  // Read for the next column is issued on phase 0, so its data is due RD_LAT edges later.
  assign capture = (ph == PH_W'(RD_LAT - 1));

endmodule

// File: rtl/led_out_serializer.sv
// led_out_serializer
//   LED-panel output engine: fetches one CH-bit column word per DCLK from
//   frame memory, shifts it out on CH parallel channels, latches each line
//   with LE, blanks across the scan-line change and steps the scan line.
// Ports:
//   clk, xrst           - clock, async active-low reset
//   start, frame_alt    - frame start pulse and bank select sampled with it
//   zero                - per-channel force-zero mask on d_out
//   rd_d                - memory read data, RD_LAT cycles after rd_cycle
//   rd_cycle, rd_adrs   - read strobe and {bank, line, col} address
//   d_out, dclk, le     - serial data, shift clock, latch enable
//   blank, scan_line    - output-enable off, current row select
//   busy, frame_done    - frame in progress, end-of-frame pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | blanked, waiting for start
// PRIME   | waiting RD_LAT cycles for the column-0 word of a line
// SHIFT   | shifting COLS columns, 2*DIV cycles each, prefetching ahead
// LATCH   | LE high for LE_W cycles, last word held
// SWITCH  | scan line advanced, blanked for BLANK_CYC cycles
// DONE    | one-cycle frame_done, back to IDLE
module led_out_serializer
  import led_out_pkg::*;
#(
  parameter int CH        = DEF_CH,
  parameter int SCAN      = DEF_SCAN,
  parameter int COLS      = DEF_COLS,
  parameter int DIV       = DEF_DIV,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int LE_W      = DEF_LE_W,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                                  clk,
  input  logic                                  xrst,
  input  logic                                  start,
  input  logic                                  frame_alt,
  input  logic [CH-1:0]                         zero,
  input  logic [CH-1:0]                         rd_d,
  output logic                                  rd_cycle,
  output logic [$clog2(SCAN)+$clog2(COLS):0]    rd_adrs,
  output logic [CH-1:0]                         d_out,
  output logic                                  dclk,
  output logic                                  le,
  output logic                                  blank,
  output logic [$clog2(SCAN)-1:0]               scan_line,
  output logic                                  busy,
  output logic                                  frame_done
);

  localparam int SCAN_W  = $clog2(SCAN);
  localparam int COL_W   = $clog2(COLS);
  localparam int ADR_W   = 1 + SCAN_W + COL_W;
  localparam int CNT_MAX = max3(RD_LAT, LE_W, BLANK_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              bank;
  logic [SCAN_W-1:0] line;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_n1;
  logic [CH-1:0]     shreg;
  logic [CH-1:0]     pre;
  logic              div_en;
  logic              col_end;
  logic              capture;

  assign col_n1 = col + COL_W'(1);

  // The divider is cleared on the final column edge so DCLK drops as LE rises.
  assign div_en = (state == ST_SHIFT) && !(col_end && (col == COL_LAST));

  led_out_divider #(
    .DIV    (DIV),
    .RD_LAT (RD_LAT)
  ) u_div (
    .clk     (clk),
    .xrst    (xrst),
    .en      (div_en),
    .dclk    (dclk),
    .col_end (col_end),
    .capture (capture)
  );

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bank       <= 1'b0;
      line       <= '0;
      col        <= '0;
      shreg      <= '0;
      pre        <= '0;
      rd_cycle   <= 1'b0;
      rd_adrs    <= '0;
      le         <= 1'b0;
      blank      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd_cycle   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bank     <= frame_alt;
            line     <= '0;
            col      <= '0;
            rd_cycle <= 1'b1;
            rd_adrs  <= ADR_W'(pack_adrs(frame_alt, 32'd0, 32'd0, SCAN_W, COL_W));
            cnt      <= CNT_W'(RD_LAT - 1);
            busy     <= 1'b1;
            blank    <= 1'b0;
            state    <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (cnt == '0) begin
            shreg    <= rd_d;
            col      <= '0;
            rd_cycle <= 1'b1;
            rd_adrs  <= ADR_W'(pack_adrs(bank, 32'(line), 32'd1, SCAN_W, COL_W));
            state    <= ST_SHIFT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (capture && (col != COL_LAST)) pre <= rd_d;
          if (col_end) begin
            if (col == COL_LAST) begin
              le    <= 1'b1;
              blank <= 1'b1;
              cnt   <= CNT_W'(LE_W - 1);
              state <= ST_LATCH;
            end else begin
              col   <= col_n1;
              shreg <= pre;
              // Prefetch one column ahead; the last column has nothing to fetch.
              if (col_n1 != COL_LAST) begin
                rd_cycle <= 1'b1;
                rd_adrs  <= ADR_W'(pack_adrs(bank, 32'(line), 32'(col_n1 + COL_W'(1)),
                                             SCAN_W, COL_W));
              end
            end
          end
        end
        ST_LATCH: begin
          if (cnt == '0) begin
            le    <= 1'b0;
            line  <= line + SCAN_W'(1);
            cnt   <= CNT_W'(BLANK_CYC - 1);
            state <= ST_SWITCH;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_SWITCH: begin
          if (cnt == '0) begin
            // line has already advanced; a wrap to 0 means the frame is complete.
            if (line == '0) begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              rd_cycle <= 1'b1;
              rd_adrs  <= ADR_W'(pack_adrs(bank, 32'(line), 32'd0, SCAN_W, COL_W));
              cnt      <= CNT_W'(RD_LAT - 1);
              blank    <= 1'b0;
              state    <= ST_PRIME;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign scan_line = line;
  assign d_out     = shreg & ~zero;

endmodule

// File: tb/tb_led_out_serializer.sv
// tb_led_out_serializer
//   Two instances: A (DIV=2, RD_LAT=2) and B (DIV=1, RD_LAT=1), both CH=4,
//   SCAN=2, COLS=4. Each has a frame memory whose word equals its 4-bit
//   address, valid only in the cycle RD_LAT after the read strobe.
module tb_led_out_serializer;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic start = 1'b0;
  logic start_b = 1'b0;
  logic frame_alt = 1'b0;
  logic [3:0] zero = 4'd0;

  logic       a_rd_cycle, a_dclk, a_le, a_blank, a_busy, a_frame_done;
  logic [3:0] a_rd_adrs, a_rd_d, a_d_out;
  logic [0:0] a_scan_line;
  logic       b_rd_cycle, b_dclk, b_le, b_blank, b_busy, b_frame_done;
  logic [3:0] b_rd_adrs, b_rd_d, b_d_out;
  logic [0:0] b_scan_line;

  int checks = 0;
  int errors = 0;

  // Cycles per line for instance A: RD_LAT + COLS*2*DIV + LE_W + BLANK_CYC.
  localparam int LINE_A = 2 + 16 + 2 + 4;
  localparam int LINE_B = 1 + 8 + 2 + 4;

  always #5 clk = ~clk;

  led_out_serializer #(
    .CH(4), .SCAN(2), .COLS(4), .DIV(2), .RD_LAT(2), .LE_W(2), .BLANK_CYC(4)
  ) u_a (
    .clk(clk), .xrst(xrst), .start(start), .frame_alt(frame_alt), .zero(zero),
    .rd_d(a_rd_d), .rd_cycle(a_rd_cycle), .rd_adrs(a_rd_adrs), .d_out(a_d_out),
    .dclk(a_dclk), .le(a_le), .blank(a_blank), .scan_line(a_scan_line),
    .busy(a_busy), .frame_done(a_frame_done)
  );

  led_out_serializer #(
    .CH(4), .SCAN(2), .COLS(4), .DIV(1), .RD_LAT(1), .LE_W(2), .BLANK_CYC(4)
  ) u_b (
    .clk(clk), .xrst(xrst), .start(start_b), .frame_alt(frame_alt), .zero(zero),
    .rd_d(b_rd_d), .rd_cycle(b_rd_cycle), .rd_adrs(b_rd_adrs), .d_out(b_d_out),
    .dclk(b_dclk), .le(b_le), .blank(b_blank), .scan_line(b_scan_line),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  // Memory A: registered address, data valid one cycle after the strobe cycle.
  logic       a_v = 1'b0;
  logic [3:0] a_q = 4'd0;
  always @(posedge clk) begin
    a_v <= a_rd_cycle;
    a_q <= a_rd_adrs;
  end
  assign a_rd_d = a_v ? a_q : ~a_q;

  // Memory B: data valid in the strobe cycle itself.
  assign b_rd_d = b_rd_cycle ? b_rd_adrs : ~b_rd_adrs;

  typedef struct {
    logic        alt;
    logic [3:0]  zero;
    logic        poke;
    logic [31:0] exp;   // d_out at the 8 dclk rises, first rise in the top nibble
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame_a(input vec_t v);
    int rises = 0;
    int reads = 0;
    int busy_cyc = 0;
    int done_cnt = 0;
    int done_c = -1;
    int le_cyc = 0;
    int n_le = 0;
    int unblank = 0;
    int fall_c = -1;
    int sl_chg = 0;
    logic poked = 1'b0;
    logic prev_dclk = 1'b0;
    logic prev_le = 1'b0;
    logic [0:0] prev_sl = a_scan_line;
    logic [3:0] exp_w;
    zero = v.zero;
    frame_alt = v.alt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame_alt = ~v.alt;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      if (!a_busy) break;
      busy_cyc++;
      if (a_rd_cycle) begin
        chk("a_rd_adrs", 32'(a_rd_adrs), 32'({v.alt, 3'(reads)}));
        reads++;
      end
      if (a_dclk && !prev_dclk) begin
        if (rises < 8) begin
          exp_w = v.exp[31-4*rises -: 4];
          chk("a_d_out_at_rise", 32'(a_d_out), 32'(exp_w));
          chk("a_scan_at_rise", 32'(a_scan_line), 32'(rises / 4));
        end
        rises++;
      end
      if (!a_dclk && prev_dclk) fall_c = c;
      if (a_le && !prev_le) begin
        chk("a_le_at_dclk_fall", 32'(c), 32'(fall_c));
        chk("a_le_after_rises", 32'(rises), 32'(4 * (n_le + 1)));
        n_le++;
      end
      if (a_le) le_cyc++;
      if (!a_blank) unblank++;
      if (a_scan_line != prev_sl) sl_chg++;
      if (a_frame_done) begin
        done_cnt++;
        done_c = c;
      end
      start = v.poke && (rises == 5) && !poked;
      if (start) poked = 1'b1;
      prev_dclk = a_dclk;
      prev_le = a_le;
      prev_sl = a_scan_line;
    end
    start = 1'b0;
    chk("a_busy_cycles", 32'(busy_cyc), 32'(2 * LINE_A + 1));
    chk("a_frame_done_count", 32'(done_cnt), 32'd1);
    chk("a_frame_done_cycle", 32'(done_c), 32'(2 * LINE_A));
    chk("a_rises", 32'(rises), 32'd8);
    chk("a_reads", 32'(reads), 32'd8);
    chk("a_le_cycles", 32'(le_cyc), 32'd4);
    chk("a_unblank_cycles", 32'(unblank), 32'(2 * (2 + 16)));
    chk("a_scan_changes", 32'(sl_chg), 32'd2);
    chk("a_scan_end", 32'(a_scan_line), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("a_idle_after_frame", 32'({a_busy, a_frame_done, a_blank}), 32'b001);
    end
    zero = 4'd0;
  endtask

  task automatic run_frame_b();
    int rises = 0;
    int reads = 0;
    int busy_cyc = 0;
    int done_cnt = 0;
    int last_rise = 0;
    logic prev_dclk = 1'b0;
    logic [3:0] exp_w;
    frame_alt = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    frame_alt = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      if (!b_busy) break;
      busy_cyc++;
      if (b_rd_cycle) begin
        chk("b_rd_adrs", 32'(b_rd_adrs), 32'(8 + reads));
        reads++;
      end
      if (b_dclk && !prev_dclk) begin
        exp_w = 4'(8 + rises);
        chk("b_d_out_at_rise", 32'(b_d_out), 32'(exp_w));
        if (rises % 4 != 0) chk("b_rise_gap", 32'(c - last_rise), 32'd2);
        last_rise = c;
        rises++;
      end
      if (b_frame_done) done_cnt++;
      prev_dclk = b_dclk;
    end
    chk("b_busy_cycles", 32'(busy_cyc), 32'(2 * LINE_B + 1));
    chk("b_rises", 32'(rises), 32'd8);
    chk("b_reads", 32'(reads), 32'd8);
    chk("b_frame_done_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int n_le;
    logic prev_le;
    vecs[0] = '{alt: 1'b0, zero: 4'h0, poke: 1'b0, exp: 32'h0123_4567};
    vecs[1] = '{alt: 1'b1, zero: 4'h0, poke: 1'b0, exp: 32'h89AB_CDEF};
    vecs[2] = '{alt: 1'b0, zero: 4'hA, poke: 1'b0, exp: 32'h0101_4545};
    vecs[3] = '{alt: 1'b1, zero: 4'hA, poke: 1'b0, exp: 32'h0101_4545};
    vecs[4] = '{alt: 1'b1, zero: 4'h5, poke: 1'b0, exp: 32'h88AA_88AA};
    vecs[5] = '{alt: 1'b0, zero: 4'h0, poke: 1'b1, exp: 32'h0123_4567};

    repeat (3) @(negedge clk);
    chk("rst_rd_cycle", 32'(a_rd_cycle), 32'd0);
    chk("rst_rd_adrs", 32'(a_rd_adrs), 32'd0);
    chk("rst_d_out", 32'(a_d_out), 32'd0);
    chk("rst_dclk", 32'(a_dclk), 32'd0);
    chk("rst_le", 32'(a_le), 32'd0);
    chk("rst_blank", 32'(a_blank), 32'd1);
    chk("rst_scan_line", 32'(a_scan_line), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_frame_done", 32'(a_frame_done), 32'd0);
    xrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_blank", 32'({a_blank, a_busy, a_dclk, a_le}), 32'b1000);

    for (int i = 0; i < 6; i++) run_frame_a(vecs[i]);

    // Reset during the LATCH of line 1.
    frame_alt = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_le = 0;
    prev_le = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (a_le && !prev_le) n_le++;
      if (n_le == 2) break;
      prev_le = a_le;
      @(negedge clk);
    end
    chk("latch_reached", 32'(n_le), 32'd2);
    chk("latch_scan_line", 32'(a_scan_line), 32'd1);
    #1 xrst = 1'b0;
    #1;
    chk("arst_le", 32'(a_le), 32'd0);
    chk("arst_busy", 32'(a_busy), 32'd0);
    chk("arst_rd_cycle", 32'(a_rd_cycle), 32'd0);
    chk("arst_blank", 32'(a_blank), 32'd1);
    chk("arst_scan_line", 32'(a_scan_line), 32'd0);
    chk("arst_d_out", 32'(a_d_out), 32'd0);
    @(negedge clk);
    xrst = 1'b1;
    @(negedge clk);
    run_frame_a(vecs[0]);

    run_frame_b();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
